// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Transmit buffer for the UART: DEPTH-entry byte FIFO drained into the transmitter
// through a start_tx/busy level handshake by a three-state launch FSM.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  overflow_clr_i,
  input  logic                  busy_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  start_tx_o,
  output logic [DATA_WIDTH-1:0] xmit_data_o,
  output logic                  idle_o
);

  // Handshake: start_tx_o is a level request held in LAUNCH until busy_i is
  // sampled high; the next launch waits for busy_i low plus one IDLE cycle.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] xmit_q, xmit_d;
  logic                  full, empty, wr_accept, wr_drop, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en_i & ~full;
  assign wr_drop   = wr_en_i & full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && !busy_i) begin
          pop     = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (busy_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    xmit_d   = pop ? mem_q[rd_ptr_q] : xmit_q;
    count_d  = count_q;
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped write wins over a clear arriving in the same cycle.
    if (wr_drop)             ovf_d = 1'b1;
    else if (overflow_clr_i) ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      xmit_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      xmit_q   <= xmit_d;
    end
  end

  // Storage holds no reset; stale contents are never read past count.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign start_tx_o  = (state_q == ST_LAUNCH);
  assign xmit_data_o = xmit_q;
  assign idle_o      = empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a
// queue-based reference model and a line-side scoreboard of transmitted bytes.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          overflow_clr_i;
  logic          busy_i;
  logic          full_o, empty_o, overflow_o, start_tx_o, idle_o;
  logic [CW-1:0] count_o;
  logic [DW-1:0] xmit_data_o;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .overflow_clr_i(overflow_clr_i), .busy_i(busy_i), .full_o(full_o),
    .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .start_tx_o(start_tx_o), .xmit_data_o(xmit_data_o), .idle_o(idle_o)
  );

  // Reference model: buffered bytes, launcher phase (0 idle, 1 requesting,
  // 2 waiting for busy to drop), presented byte and sticky overflow.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  int            ph;
  logic [DW-1:0] m_xmit;
  logic          m_ovf;
  int            tx_st, tx_cnt, sent_cnt;
  bit            glitch_en;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    ph = 0; m_xmit = '0; m_ovf = 1'b0; tx_st = 0; tx_cnt = 0;
  endtask

  task automatic check_outputs();
    check_val("count", count_o, model_q.size());
    check_val("full", full_o, model_q.size() == DEPTH);
    check_val("empty", empty_o, model_q.size() == 0);
    check_val("overflow", overflow_o, m_ovf);
    check_val("start_tx", start_tx_o, ph == 1);
    check_val("xmit_data", xmit_data_o, m_xmit);
    check_val("idle", idle_o, (model_q.size() == 0) && (ph == 0));
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic c, input logic b);
    bit full_now, pop;
    full_now = (model_q.size() == DEPTH);
    pop = (ph == 0) && (model_q.size() != 0) && !b;
    if (pop) begin
      m_xmit = model_q.pop_front();
      ph = 1;
    end else if (ph == 1 && b) ph = 2;
    else if (ph == 2 && !b) ph = 0;
    if (w && full_now) m_ovf = 1'b1;
    else begin
      if (w) begin
        model_q.push_back(d);
        exp_q.push_back(d);
      end
      if (c) m_ovf = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic c, input logic b);
    logic [31:0] exp_byte;
    wr_en_i = w; wr_data_i = d; overflow_clr_i = c; busy_i = b;
    if (b && start_tx_o) begin
      exp_byte = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'hDEAD;
      check_val("tx_byte", xmit_data_o, exp_byte);
      sent_cnt++;
    end
    @(posedge clk);
    model_step(w, d, c, b);
    @(negedge clk);
    check_outputs();
  endtask

  // Transmitter model: acknowledges a request after 0-2 cycles, stays busy 1-5 cycles.
  task automatic tx_busy(output logic b);
    b = 1'b0;
    case (tx_st)
      0: begin
        if (start_tx_o) begin
          tx_cnt = $urandom_range(0, 2);
          if (tx_cnt == 0) begin b = 1'b1; tx_st = 2; tx_cnt = $urandom_range(0, 4); end
          else tx_st = 1;
        end else if (glitch_en) b = ($urandom_range(0, 9) == 0);
      end
      1: begin
        tx_cnt--;
        if (tx_cnt == 0) begin b = 1'b1; tx_st = 2; tx_cnt = $urandom_range(0, 4); end
      end
      default: begin
        if (tx_cnt == 0) tx_st = 0;
        else begin b = 1'b1; tx_cnt--; end
      end
    endcase
  endtask

  task automatic acycle(input logic w, input logic [DW-1:0] d, input logic c);
    logic b;
    tx_busy(b);
    cycle(w, d, c, b);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((model_q.size() != 0 || ph != 0 || tx_st != 0) && guard < 3000) begin
      acycle(1'b0, '0, 1'b0);
      guard++;
    end
    check_val({tag, "_drain_in_time"}, guard < 3000, 1);
    check_val({tag, "_drain_count"}, count_o, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    wr_en_i = 1'b0; overflow_clr_i = 1'b0; busy_i = 1'b0;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; overflow_clr_i = 1'b0; busy_i = 1'b0;
    glitch_en = 1'b0; sent_cnt = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single byte with a slow transmitter.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check_val("t1_empty_low", empty_o, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("t1_start_rise", start_tx_o, 1);
    check_val("t1_data", xmit_data_o, 8'hA5);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (100) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("t1_data_hold", xmit_data_o, 8'hA5);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("t1_idle", idle_o, 1);

    // Burst into a busy transmitter, then overflow handling.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    check_val("burst_full", full_o, 1);
    check_val("burst_count", count_o, DEPTH);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1);
    check_val("ovf_set", overflow_o, 1);
    check_val("ovf_count", count_o, DEPTH);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    check_val("ovf_set_beats_clr", overflow_o, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_val("ovf_clr", overflow_o, 0);
    drain("burst");

    // Write coinciding with a pop.
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    check_val("simul_count", count_o, 1);
    drain("simul");

    // Wrap-around: 40 bytes in groups of five while draining.
    sent_cnt = 0;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) acycle(1'b1, DW'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(40, 60)) acycle(1'b0, '0, 1'b0);
    end
    drain("wrap");
    check_val("wrap_sent", sent_cnt, 40);
    check_val("wrap_no_ovf", overflow_o, 0);

    // Reset while waiting for the transmitter with bytes buffered.
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b1);
    check_val("rst_pre_count", count_o, 6);
    do_reset();
    repeat (10) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("rst_no_start", start_tx_o, 0);

    // Random traffic with busy glitches and occasional overflow clears.
    glitch_en = 1'b1;
    for (int i = 0; i < 1500; i++)
      acycle($urandom_range(0, 2) == 0, DW'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    glitch_en = 1'b0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
